// File: rtl/conv1d_pkg.sv
// Shared constants, config bundle and saturation helper
// for the conv1d requantise/pack block.
package conv1d_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int LANE_W    = 8;
  localparam int LANES     = 4;

  localparam logic [1:0] CFG_BIAS  = 2'd0;
  localparam logic [1:0] CFG_MULT  = 2'd1;
  localparam logic [1:0] CFG_SHIFT = 2'd2;
  localparam logic [1:0] CFG_ACT   = 2'd3;

  typedef struct packed {
    logic signed [31:0] bias;
    logic signed [31:0] mult;
    logic        [5:0]  shift;
    logic signed [8:0]  offset;
    logic signed [7:0]  act_min;
    logic signed [7:0]  act_max;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    bias:    32'h0,
    mult:    32'h1,
    shift:   6'h0,
    offset:  9'h0,
    act_min: 8'h80,
    act_max: 8'h7f
  };

  function automatic logic [LANE_W-1:0] sat8(
    input logic signed [66:0] v,
    input logic signed [7:0]  lo,
    input logic signed [7:0]  hi
  );
    logic signed [66:0] l;
    logic signed [66:0] h;
    l = {{59{lo[7]}}, lo};
    h = {{59{hi[7]}}, hi};
    if (v < l)      sat8 = lo;
    else if (v > h) sat8 = hi;
    else            sat8 = v[7:0];
  endfunction

endpackage

// File: rtl/conv1d_requant_packer_if.sv
// Valid/ready stream used for the accumulator input
// and the packed-word output.
interface conv1d_stream_if #(
  parameter int W = 32
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/conv1d_out_fifo.sv
// Synchronous first-word-fall-through FIFO;
// push into a full FIFO succeeds only alongside a pop.
module conv1d_out_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign count   = wp - rp;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/conv1d_requant_packer.sv
// Three-stage int32 -> int8 requantiser feeding a
// four-lane byte packer and an output word FIFO.
module conv1d_requant_packer
  import conv1d_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  conv1d_stream_if.slave   acc,
  conv1d_stream_if.master  res,
  input  logic             flush,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_data,
  output logic             busy,
  output logic             cfg_err
);
  localparam int CW = $clog2(DEPTH) + 1;

  cfg_t cfg;

  logic stall;
  logic flush_pend;
  logic flush_req;

  logic               s1_v, s1_f;
  logic signed [32:0] s1_sum;
  logic               s2_v, s2_f;
  logic signed [65:0] s2_r;
  logic               s3_v, s3_f;
  logic [7:0]         s3_b;

  logic [2:0]              cnt;
  logic [LANES-1:0][7:0]   lanes;
  logic                    pk_v;
  logic [31:0]             pk_word;

  logic          f_full;
  logic          f_empty;
  logic [CW-1:0] f_count;

  logic signed [32:0] sum_c;
  logic signed [65:0] op_a, op_b, prod, rnd, r_c;
  logic signed [66:0] v_c;
  logic [7:0]         byte_c;

  logic [LANES-1:0][7:0] nl;
  logic [2:0]            nn;
  logic                  emit;

  // A completed word blocks only if it cannot leave this cycle.
  assign stall     = pk_v & f_full & ~res.ready;
  assign acc.ready = ~stall;
  assign flush_req = flush | flush_pend;

  always_comb begin
    sum_c  = {acc.data[31], acc.data} + {cfg.bias[31], cfg.bias};
    op_a   = {{33{s1_sum[32]}}, s1_sum};
    op_b   = {{34{cfg.mult[31]}}, cfg.mult};
    prod   = op_a * op_b;
    rnd    = '0;
    if (cfg.shift != 6'd0) rnd = 66'sd1 <<< (cfg.shift - 6'd1);
    r_c    = (prod + rnd) >>> cfg.shift;
    v_c    = {s2_r[65], s2_r} + {{58{cfg.offset[8]}}, cfg.offset};
    byte_c = sat8(v_c, cfg.act_min, cfg.act_max);
  end

  always_comb begin
    nl = lanes;
    nn = cnt;
    if (s3_v) begin
      nl[cnt[1:0]] = s3_b;
      nn           = cnt + 3'd1;
    end
    emit = (nn == 3'd4) | (s3_f & (nn != 3'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg     <= CFG_RST;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we & busy;
      if (cfg_we & ~busy) begin
        unique case (1'b1)
          (cfg_addr == CFG_BIAS):  cfg.bias  <= cfg_data;
          (cfg_addr == CFG_MULT):  cfg.mult  <= cfg_data;
          (cfg_addr == CFG_SHIFT): cfg.shift <= cfg_data[5:0];
          (cfg_addr == CFG_ACT): begin
            cfg.offset  <= cfg_data[8:0];
            cfg.act_min <= cfg_data[23:16];
            cfg.act_max <= cfg_data[31:24];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_pend <= 1'b0;
      s1_v <= 1'b0; s1_f <= 1'b0; s1_sum <= '0;
      s2_v <= 1'b0; s2_f <= 1'b0; s2_r   <= '0;
      s3_v <= 1'b0; s3_f <= 1'b0; s3_b   <= '0;
      cnt  <= '0;
      lanes <= '0;
      pk_v <= 1'b0;
      pk_word <= '0;
    end else if (stall) begin
      flush_pend <= flush_pend | flush;
    end else begin
      flush_pend <= 1'b0;
      s1_v   <= acc.valid;
      s1_f   <= flush_req;
      s1_sum <= sum_c;
      s2_v   <= s1_v;
      s2_f   <= s1_f;
      s2_r   <= r_c;
      s3_v   <= s2_v;
      s3_f   <= s2_f;
      s3_b   <= byte_c;
      pk_v   <= emit;
      if (emit) begin
        pk_word <= nl;
        cnt     <= '0;
        lanes   <= '0;
      end else begin
        cnt   <= nn;
        lanes <= nl;
      end
    end
  end

  conv1d_out_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pk_v & ~stall),
    .din   (pk_word),
    .pop   (res.ready),
    .dout  (res.data),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign res.valid = ~f_empty;

  assign busy = s1_v | s1_f | s2_v | s2_f | s3_v | s3_f |
                flush_pend | (cnt != 3'd0) | pk_v |
                (f_count != '0);

endmodule

// File: tb/tb_conv1d_requant_packer.sv
// Scoreboard bench: directed samples push expected words,
// a negedge monitor pops and compares emitted words.
module tb_conv1d_requant_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        busy;
  logic        cfg_err;

  conv1d_stream_if #(.W(32)) acc ();
  conv1d_stream_if #(.W(32)) res ();

  always #5 clk = ~clk;

  conv1d_requant_packer #(.DEPTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .acc      (acc),
    .res      (res),
    .flush    (flush),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  logic        held = 1'b0;
  logic [31:0] held_d = '0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (res.valid && held) check("hold", res.data, held_d);
      if (res.valid && res.ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL word: got %h want none", res.data);
        end else begin
          check("word", res.data, exp_q.pop_front());
        end
      end
      held   = res.valid && !res.ready;
      held_d = res.data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input bit f);
    bit ok;
    int k;
    acc.valid = 1'b1;
    acc.data  = 32'(a);
    flush     = f;
    k = 0;
    do begin
      @(negedge clk);
      ok = acc.ready;
      @(posedge clk);
      #1;
      k++;
    end while (!ok && k < 500);
    if (!ok) timeout("send");
    acc.valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 2000) begin
      tick();
      k++;
    end
    if (k >= 2000) timeout("idle");
  endtask

  task automatic cfg(input logic [1:0] a, input logic [31:0] d);
    wait_idle();
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  function automatic logic [7:0] vb(input int i);
    return 8'(i * 3 - 100);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    acc.valid = 1'b0;
    acc.data  = '0;
    res.ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 32'(res.valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_in_ready", 32'(acc.ready), 32'd1);
    reset = 1'b0;
    tick();

    // identity requant, saturation both ways, latency
    exp_q.push_back(32'h807FFD05);
    send(5, 0);
    send(-3, 0);
    send(200, 0);
    send(-200, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_t3", 32'(res.valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_t4", 32'(res.valid), 32'd1);
    wait_idle();

    // partial word via flush, then flush with nothing pending
    exp_q.push_back(32'h00000001);
    send(1, 0);
    do_flush();
    wait_idle();
    do_flush();
    repeat (10) tick();
    check("empty_flush_busy", 32'(busy), 32'd0);
    check("empty_flush_valid", 32'(res.valid), 32'd0);

    // flush together with a sample
    exp_q.push_back(32'h0000FE02);
    send(2, 0);
    send(-2, 1);
    wait_idle();

    // mult=3, shift=2 rounding half up
    cfg(CFG_MULT_A(), 32'd3);
    cfg(2'd2, 32'd2);
    exp_q.push_back(32'h0002FB05);
    send(7, 0);
    send(-7, 0);
    send(2, 0);
    send(0, 0);
    wait_idle();

    // bias/offset/clamp: bytes 80,81,80,80 in lanes 0..3
    cfg(2'd0, 32'hFFFFFF9C);
    cfg(2'd1, 32'd1);
    cfg(2'd2, 32'd0);
    cfg(2'd3, 32'h0080_0180);
    exp_q.push_back(32'h80808180);
    send(100, 0);
    send(101, 0);
    send(99, 0);
    send(0, 0);
    wait_idle();

    cfg(2'd0, 32'd0);
    cfg(2'd3, 32'h7F80_0000);

    // backpressure: 70 samples into a stalled output
    res.ready = 1'b0;
    for (int w = 0; w < 17; w++)
      exp_q.push_back({vb(4*w+3), vb(4*w+2), vb(4*w+1), vb(4*w)});
    for (int i = 0; i < 70; i++) send(i * 3 - 100, 0);
    repeat (4) tick();
    check("bp_in_ready", 32'(acc.ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    res.ready = 1'b1;
    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 500) begin
        tick();
        k++;
      end
      if (k >= 500) timeout("drain");
    end
    repeat (5) tick();
    check("bp_tail_busy", 32'(busy), 32'd1);

    // config write while busy is refused
    cfg_we   = 1'b1;
    cfg_addr = 2'd1;
    cfg_data = 32'd5;
    tick();
    cfg_we   = 1'b0;
    check("cfg_err_pulse", 32'(cfg_err), 32'd1);
    tick();
    check("cfg_err_clear", 32'(cfg_err), 32'd0);
    exp_q.push_back({16'h0000, vb(69), vb(68)});
    do_flush();
    wait_idle();
    exp_q.push_back(32'h281E140A);
    send(10, 0);
    send(20, 0);
    send(30, 0);
    send(40, 0);
    wait_idle();

    // reset mid-burst with three words queued
    cfg(2'd1, 32'd2);
    res.ready = 1'b0;
    for (int i = 1; i <= 12; i++) send(i, 0);
    repeat (6) tick();
    check("pre_rst_valid", 32'(res.valid), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(res.valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(acc.ready), 32'd1);
    reset = 1'b0;
    res.ready = 1'b1;
    repeat (10) tick();
    check("post_rst_valid", 32'(res.valid), 32'd0);
    exp_q.push_back(32'h04030201);
    send(1, 0);
    send(2, 0);
    send(3, 0);
    send(4, 0);
    wait_idle();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  function automatic logic [1:0] CFG_MULT_A();
    return 2'd1;
  endfunction

endmodule
